riscv_dmem_uncached_ctrl: RTL and testbench

- Parametrised uncached data-memory controller between the CPU memory stage and the BIU, for configurations without a data cache.
- Supports up to DEPTH outstanding single transfers, each tracked in a per-request attribute queue.
- Right-aligns and sign/zero-extends load data, and replicates store data across byte lanes.
- Discards stale responses after a misalignment, a bus error or a pipeline kill.

---
 rtl/biu_constants_pkg.sv | 28 ++
 rtl/riscv_dmem_uncached_ctrl_pkg.sv | 17 +
 rtl/riscv_state_pkg.sv | 9 +
 rtl/riscv_dmem_attr_fifo.sv | 49 ++++
 rtl/riscv_dmem_uncached_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_riscv_dmem_uncached_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/biu_constants_pkg.sv
// Bus interface unit encodings shared by the CPU memory-side blocks.
package biu_constants_pkg;

    typedef enum logic [2:0] {
        BYTE  = 3'b000,
        HWORD = 3'b001,
        WORD  = 3'b010,
        DWORD = 3'b011,
        QWORD = 3'b100
    } biu_size_t;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101
    } biu_type_t;

    typedef logic [2:0] biu_prot_t;

    localparam biu_prot_t PROT_INSTRUCTION = 3'b000;
    localparam biu_prot_t PROT_DATA        = 3'b001;
    localparam biu_prot_t PROT_USER        = 3'b000;
    localparam biu_prot_t PROT_PRIVILEGED  = 3'b010;

endpackage

// File: rtl/riscv_dmem_uncached_ctrl_pkg.sv
// Per-request attribute record for the uncached data-memory controller.
// The adr field exists only when RV_DMEM_ERR_ADR_EN is defined.
package riscv_dmem_uncached_ctrl_pkg;
    import biu_constants_pkg::*;

    localparam int MAX_XLEN = 64;

    typedef struct packed {
        biu_size_t             size;
        logic [2:0]            offset;
        logic                  is_unsigned;
`ifdef RV_DMEM_ERR_ADR_EN
        logic [MAX_XLEN-1:0]   adr;
`endif
    } dmem_attr_t;

endpackage

// File: rtl/riscv_state_pkg.sv
// RISC-V privilege level encodings.
package riscv_state_pkg;

    localparam logic [1:0] PRV_U = 2'b00;
    localparam logic [1:0] PRV_S = 2'b01;
    localparam logic [1:0] PRV_H = 2'b10;
    localparam logic [1:0] PRV_M = 2'b11;

endpackage

// File: rtl/riscv_dmem_attr_fifo.sv
// DEPTH-entry FIFO of request attributes, one entry per outstanding BIU transfer.
module riscv_dmem_attr_fifo
    import riscv_dmem_uncached_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  dmem_attr_t               d_i,
    input  logic                     pop_i,
    output dmem_attr_t               q_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    dmem_attr_t      mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push_i) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_i)  rd_ptr <= ptr_inc(rd_ptr);
            count_o <= count_o + CW'(push_i) - CW'(pop_i);
        end
    end

    // Full push with simultaneous pop overwrites the head slot after it is read.
    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_ptr] <= d_i;
    end

    assign q_o = mem[rd_ptr];

endmodule

// File: rtl/riscv_dmem_uncached_ctrl.sv
// Uncached data-memory controller between the CPU memory stage and the BIU.
// Optional RV_DMEM_ERR_ADR_EN adds mem_err_adr_o, the address of the failing transfer.
module riscv_dmem_uncached_ctrl
    import biu_constants_pkg::*;
    import riscv_state_pkg::*;
    import riscv_dmem_uncached_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ALEN  = XLEN,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mem_req_i,
    input  biu_size_t        mem_size_i,
    input  logic             mem_lock_i,
    input  logic [XLEN-1:0]  mem_adr_i,
    input  logic             mem_we_i,
    input  logic             mem_unsigned_i,
    input  logic [XLEN-1:0]  mem_d_i,
    input  logic             mem_kill_i,
    output logic [XLEN-1:0]  mem_q_o,
    output logic             mem_ack_o,
    output logic             mem_err_o,
    output logic             mem_misaligned_o,
`ifdef RV_DMEM_ERR_ADR_EN
    output logic [XLEN-1:0]  mem_err_adr_o,
`endif
    input  logic [1:0]       st_prv_i,
    output logic             biu_stb_o,
    output logic [ALEN-1:0]  biu_adri_o,
    input  logic [ALEN-1:0]  biu_adro_i,
    output biu_size_t        biu_size_o,
    output biu_type_t        biu_type_o,
    output logic             biu_lock_o,
    output logic             biu_we_o,
    output biu_prot_t        biu_prot_o,
    output logic [XLEN-1:0]  biu_d_o,
    input  logic [XLEN-1:0]  biu_q_i,
    input  logic             biu_stb_ack_i,
    input  logic             biu_d_ack_i,
    input  logic             biu_ack_i,
    input  logic             biu_err_i
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(XLEN / 8);

    logic             hold_req, hold_lock, hold_we, hold_uns;
    biu_size_t        hold_size;
    logic [XLEN-1:0]  hold_adr, hold_d;
    biu_size_t        sel_size;
    logic [XLEN-1:0]  sel_adr, sel_d;
    logic             sel_uns, req_any, mis_raw, misaligned;
    logic             resp, full, push, flush_cond;
    logic [CW-1:0]    inflight, discard;
    dmem_attr_t       push_attr, head;
    logic [XLEN-1:0]  shifted;
    int               ext_w;

    wire unused = ^{biu_adro_i, biu_d_ack_i};

    assign sel_size = hold_req ? hold_size : mem_size_i;
    assign sel_adr  = hold_req ? hold_adr  : mem_adr_i;
    assign sel_d    = hold_req ? hold_d    : mem_d_i;
    assign sel_uns  = hold_req ? hold_uns  : mem_unsigned_i;
    assign req_any  = mem_req_i | hold_req;

    always_comb begin
        mis_raw = 1'b1;
        case (sel_size)
            BYTE:    mis_raw = 1'b0;
            HWORD:   mis_raw = sel_adr[0];
            WORD:    mis_raw = |sel_adr[1:0];
            DWORD:   mis_raw = (|sel_adr[2:0]) | (XLEN == 32);
            default: mis_raw = 1'b1;
        endcase
    end
    assign misaligned = req_any & mis_raw;

    // Handshake: a transfer is issued in the cycle biu_stb_o and biu_stb_ack_i are both high;
    // the request stays parked in the hold register until then.
    assign resp       = (biu_ack_i | biu_err_i) & (inflight != '0);
    assign full       = (inflight == CW'(DEPTH)) & ~resp;
    assign biu_stb_o  = req_any & ~misaligned & ~mem_kill_i & ~full;
    assign push       = biu_stb_o & biu_stb_ack_i;
    assign mem_ack_o  = biu_ack_i & (inflight != '0) & (discard == '0);
    assign mem_err_o  = biu_err_i & (inflight != '0) & (discard == '0);
    assign flush_cond = misaligned | mem_err_o | mem_kill_i;

    assign biu_adri_o = ALEN'(sel_adr);
    assign biu_size_o = sel_size;
    assign biu_type_o = SINGLE;
    assign biu_lock_o = hold_req ? hold_lock : mem_lock_i;
    assign biu_we_o   = hold_req ? hold_we   : mem_we_i;
    assign biu_prot_o = PROT_DATA | ((st_prv_i == PRV_U) ? PROT_USER : PROT_PRIVILEGED);

    always_comb begin
        case (sel_size)
            BYTE:    biu_d_o = {(XLEN/8){sel_d[7:0]}};
            HWORD:   biu_d_o = {(XLEN/16){sel_d[15:0]}};
            WORD:    biu_d_o = {(XLEN/32){sel_d[31:0]}};
            default: biu_d_o = sel_d;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_req  <= 1'b0;
            hold_size <= BYTE;
            hold_lock <= 1'b0;
            hold_adr  <= '0;
            hold_we   <= 1'b0;
            hold_uns  <= 1'b0;
            hold_d    <= '0;
        end else if (push | flush_cond) begin
            hold_req  <= 1'b0;
        end else if (mem_req_i & ~hold_req) begin
            hold_req  <= 1'b1;
            hold_size <= mem_size_i;
            hold_lock <= mem_lock_i;
            hold_adr  <= mem_adr_i;
            hold_we   <= mem_we_i;
            hold_uns  <= mem_unsigned_i;
            hold_d    <= mem_d_i;
        end
    end

    // Outstanding responses at flush time are counted off and swallowed as they return.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            discard          <= '0;
            mem_misaligned_o <= 1'b0;
        end else begin
            mem_misaligned_o <= misaligned;
            if (flush_cond)                discard <= resp ? inflight - 1'b1 : inflight;
            else if (resp && discard != 0) discard <= discard - 1'b1;
        end
    end

    always_comb begin
        push_attr             = '0;
        push_attr.size        = sel_size;
        push_attr.offset      = 3'(sel_adr[OW-1:0]);
        push_attr.is_unsigned = sel_uns;
`ifdef RV_DMEM_ERR_ADR_EN
        push_attr.adr         = MAX_XLEN'(sel_adr);
`endif
    end

    riscv_dmem_attr_fifo #(.DEPTH(DEPTH)) u_attr_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (1'b0),
        .push_i  (push),
        .d_i     (push_attr),
        .pop_i   (resp),
        .q_o     (head),
        .count_o (inflight)
    );

    assign shifted = biu_q_i >> {head.offset[OW-1:0], 3'b000};

    always_comb begin
        case (head.size)
            BYTE:    ext_w = 8;
            HWORD:   ext_w = 16;
            WORD:    ext_w = 32;
            default: ext_w = XLEN;
        endcase
        mem_q_o = shifted;
        for (int i = 0; i < XLEN; i++) begin
            if (i >= ext_w) mem_q_o[i] = ~head.is_unsigned & shifted[ext_w-1];
        end
    end

`ifdef RV_DMEM_ERR_ADR_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          mem_err_adr_o <= '0;
        else if (mem_err_o) mem_err_adr_o <= head.adr[XLEN-1:0];
    end
`endif

endmodule

// File: tb/tb_riscv_dmem_uncached_ctrl.sv
// Directed bench for riscv_dmem_uncached_ctrl, XLEN=32, DEPTH=2.
module tb_riscv_dmem_uncached_ctrl;
    import biu_constants_pkg::*;

    localparam int XLEN = 32;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             mem_req_i, mem_lock_i, mem_we_i, mem_unsigned_i, mem_kill_i;
    biu_size_t        mem_size_i;
    logic [XLEN-1:0]  mem_adr_i, mem_d_i, mem_q_o, biu_d_o, biu_q_i, biu_adri_o, biu_adro_i;
    logic             mem_ack_o, mem_err_o, mem_misaligned_o;
    logic [1:0]       st_prv_i;
    logic             biu_stb_o, biu_lock_o, biu_we_o;
    biu_size_t        biu_size_o;
    biu_type_t        biu_type_o;
    biu_prot_t        biu_prot_o;
    logic             biu_stb_ack_i, biu_d_ack_i, biu_ack_i, biu_err_i;
`ifdef RV_DMEM_ERR_ADR_EN
    logic [XLEN-1:0]  mem_err_adr_o;
`endif

    int total = 0;
    int bad   = 0;
    logic [XLEN-1:0] exp_q[$];

    riscv_dmem_uncached_ctrl #(.XLEN(XLEN), .DEPTH(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_req_i(mem_req_i), .mem_size_i(mem_size_i), .mem_lock_i(mem_lock_i),
        .mem_adr_i(mem_adr_i), .mem_we_i(mem_we_i), .mem_unsigned_i(mem_unsigned_i),
        .mem_d_i(mem_d_i), .mem_kill_i(mem_kill_i), .mem_q_o(mem_q_o),
        .mem_ack_o(mem_ack_o), .mem_err_o(mem_err_o), .mem_misaligned_o(mem_misaligned_o),
`ifdef RV_DMEM_ERR_ADR_EN
        .mem_err_adr_o(mem_err_adr_o),
`endif
        .st_prv_i(st_prv_i), .biu_stb_o(biu_stb_o), .biu_adri_o(biu_adri_o),
        .biu_adro_i(biu_adro_i), .biu_size_o(biu_size_o), .biu_type_o(biu_type_o),
        .biu_lock_o(biu_lock_o), .biu_we_o(biu_we_o), .biu_prot_o(biu_prot_o),
        .biu_d_o(biu_d_o), .biu_q_i(biu_q_i), .biu_stb_ack_i(biu_stb_ack_i),
        .biu_d_ack_i(biu_d_ack_i), .biu_ack_i(biu_ack_i), .biu_err_i(biu_err_i)
    );

    // Clock / reset
    always #5 clk_i = ~clk_i;

    typedef struct {
        biu_size_t        size;
        logic [XLEN-1:0]  adr;
        logic             we;
        logic             uns;
        logic [XLEN-1:0]  d;
        logic [XLEN-1:0]  q_in;
        logic [XLEN-1:0]  exp_mem_q;
        logic [XLEN-1:0]  exp_biu_d;
        logic             mis;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_req(input biu_size_t size, input logic [XLEN-1:0] adr, input logic stb_ack);
        mem_req_i      = 1'b1;
        mem_size_i     = size;
        mem_adr_i      = adr;
        mem_we_i       = 1'b0;
        mem_unsigned_i = 1'b0;
        mem_d_i        = '0;
        biu_stb_ack_i  = stb_ack;
    endtask

    task automatic idle();
        mem_req_i     = 1'b0;
        mem_kill_i    = 1'b0;
        biu_stb_ack_i = 1'b0;
        biu_ack_i     = 1'b0;
        biu_err_i     = 1'b0;
    endtask

    task automatic respond(input logic [XLEN-1:0] q);
        biu_ack_i = 1'b1;
        biu_q_i   = q;
    endtask

    // Scoreboard: every delivered ack must match the oldest expected load data
    task automatic expect_ack(input string name);
        logic [XLEN-1:0] e;
        check({name, "_ack"}, 64'(mem_ack_o), 64'd1);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_sb: got ack expected empty queue", name);
        end else begin
            e = exp_q.pop_front();
            check({name, "_q"}, 64'(mem_q_o), 64'(e));
        end
    endtask

    initial begin
        vecs[0]  = '{WORD,  32'h104, 1'b0, 1'b0, 32'h0,        32'h8000_00F0, 32'h8000_00F0, 32'h0,         1'b0};
        vecs[1]  = '{BYTE,  32'h103, 1'b0, 1'b0, 32'h0,        32'h8A00_0000, 32'hFFFF_FF8A, 32'h0,         1'b0};
        vecs[2]  = '{BYTE,  32'h103, 1'b0, 1'b1, 32'h0,        32'h8A00_0000, 32'h0000_008A, 32'h0,         1'b0};
        vecs[3]  = '{HWORD, 32'h102, 1'b1, 1'b0, 32'h1234,     32'h0,         32'h0,         32'h1234_1234, 1'b0};
        vecs[4]  = '{HWORD, 32'h102, 1'b0, 1'b0, 32'h0,        32'hBEEF_0000, 32'hFFFF_BEEF, 32'h0,         1'b0};
        vecs[5]  = '{HWORD, 32'h100, 1'b0, 1'b1, 32'h0,        32'h0000_8001, 32'h0000_8001, 32'h0,         1'b0};
        vecs[6]  = '{BYTE,  32'h101, 1'b1, 1'b0, 32'hA5,       32'h0000_7700, 32'h0000_0077, 32'hA5A5_A5A5, 1'b0};
        vecs[7]  = '{WORD,  32'h200, 1'b1, 1'b0, 32'hDEAD_BEEF,32'h0,         32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[8]  = '{WORD,  32'h102, 1'b0, 1'b0, 32'h0,        32'h0,         32'h0,         32'h0,         1'b1};
        vecs[9]  = '{HWORD, 32'h101, 1'b0, 1'b0, 32'h0,        32'h0,         32'h0,         32'h0,         1'b1};
        vecs[10] = '{DWORD, 32'h100, 1'b0, 1'b0, 32'h0,        32'h0,         32'h0,         32'h0,         1'b1};
        vecs[11] = '{BYTE,  32'h100, 1'b0, 1'b0, 32'h0,        32'h0000_007F, 32'h0000_007F, 32'h0,         1'b0};

        rst_i = 1'b1;
        idle();
        mem_size_i = BYTE; mem_adr_i = '0; mem_we_i = 1'b0; mem_unsigned_i = 1'b0;
        mem_d_i = '0; mem_lock_i = 1'b0; st_prv_i = 2'b11;
        biu_q_i = '0; biu_adro_i = '0; biu_d_ack_i = 1'b0;
        biu_ack_i = 1'b1;
        biu_err_i = 1'b1;
        #1;
        check("rst_ack", 64'(mem_ack_o), 64'd0);
        check("rst_err", 64'(mem_err_o), 64'd0);
        check("rst_mis", 64'(mem_misaligned_o), 64'd0);
        check("rst_stb", 64'(biu_stb_o), 64'd0);
        check("type_single", 64'(biu_type_o), 64'(SINGLE));
        idle();
        tick();
        tick();
        rst_i = 1'b0;
        tick();

        // Table-driven single transfers
        for (int i = 0; i < 12; i++) begin
            st_prv_i = (i % 2 == 1) ? 2'b00 : 2'b11;
            mem_req_i      = 1'b1;
            mem_size_i     = vecs[i].size;
            mem_adr_i      = vecs[i].adr;
            mem_we_i       = vecs[i].we;
            mem_unsigned_i = vecs[i].uns;
            mem_d_i        = vecs[i].d;
            biu_stb_ack_i  = ~vecs[i].mis;
            #1;
            if (!vecs[i].mis) begin
                check($sformatf("v%0d_stb", i), 64'(biu_stb_o), 64'd1);
                check($sformatf("v%0d_biu_d", i), 64'(biu_d_o), 64'(vecs[i].exp_biu_d));
                check($sformatf("v%0d_size", i), 64'(biu_size_o), 64'(vecs[i].size));
                check($sformatf("v%0d_adr", i), 64'(biu_adri_o), 64'(vecs[i].adr));
                check($sformatf("v%0d_we", i), 64'(biu_we_o), 64'(vecs[i].we));
                check($sformatf("v%0d_prot", i), 64'(biu_prot_o),
                      (i % 2 == 1) ? 64'h1 : 64'h3);
            end else begin
                check($sformatf("v%0d_stb", i), 64'(biu_stb_o), 64'd0);
            end
            tick();
            idle();
            if (!vecs[i].mis) begin
                respond(vecs[i].q_in);
                #1;
                check($sformatf("v%0d_ack", i), 64'(mem_ack_o), 64'd1);
                check($sformatf("v%0d_q", i), 64'(mem_q_o), 64'(vecs[i].exp_mem_q));
                check($sformatf("v%0d_mis", i), 64'(mem_misaligned_o), 64'd0);
            end else begin
                #1;
                check($sformatf("v%0d_mis", i), 64'(mem_misaligned_o), 64'd1);
            end
            tick();
            idle();
            check($sformatf("v%0d_ack_after", i), 64'(mem_ack_o), 64'd0);
        end
        st_prv_i = 2'b11;

        // Held request: stb_ack one cycle late, ack two cycles after that
        drive_req(WORD, 32'h104, 1'b0);
        #1 check("hold_stb0", 64'(biu_stb_o), 64'd1);
        tick();
        mem_req_i = 1'b0;
        biu_stb_ack_i = 1'b1;
        #1;
        check("hold_stb1", 64'(biu_stb_o), 64'd1);
        check("hold_adr", 64'(biu_adri_o), 64'h104);
        tick();
        idle();
        #1 check("hold_no_stb", 64'(biu_stb_o), 64'd0);
        check("hold_wait_ack", 64'(mem_ack_o), 64'd0);
        tick();
        respond(32'h8000_00F0);
        exp_q.push_back(32'h8000_00F0);
        #1 expect_ack("hold");
        tick();
        idle();

        // Three back-to-back loads against two slots
        drive_req(WORD, 32'h10, 1'b1); exp_q.push_back(32'hAAAA_0001);
        tick();
        drive_req(WORD, 32'h14, 1'b1); exp_q.push_back(32'hBBBB_0002);
        tick();
        drive_req(WORD, 32'h18, 1'b0); exp_q.push_back(32'hCCCC_0003);
        #1 check("full_stb_c2", 64'(biu_stb_o), 64'd0);
        tick();
        idle();
        #1 check("full_stb_c3", 64'(biu_stb_o), 64'd0);
        tick();
        respond(32'hAAAA_0001);
        biu_stb_ack_i = 1'b1;
        #1;
        check("full_stb_c4", 64'(biu_stb_o), 64'd1);
        check("full_adr_c4", 64'(biu_adri_o), 64'h18);
        expect_ack("ooo_a");
        tick();
        idle();
        respond(32'hBBBB_0002);
        #1 expect_ack("ooo_b");
        tick();
        respond(32'hCCCC_0003);
        #1 expect_ack("ooo_c");
        tick();
        idle();

        // Misaligned request with two transfers outstanding
        drive_req(WORD, 32'h40, 1'b1);
        tick();
        drive_req(WORD, 32'h44, 1'b1);
        tick();
        drive_req(WORD, 32'h101, 1'b0);
        #1 check("mis_stb", 64'(biu_stb_o), 64'd0);
        tick();
        idle();
        respond(32'h11);
        #1;
        check("mis_flag", 64'(mem_misaligned_o), 64'd1);
        check("mis_supp1", 64'(mem_ack_o), 64'd0);
        tick();
        respond(32'h22);
        #1 check("mis_supp2", 64'(mem_ack_o), 64'd0);
        tick();
        idle();
        drive_req(WORD, 32'h48, 1'b1);
        #1 check("mis_next_stb", 64'(biu_stb_o), 64'd1);
        tick();
        idle();
        respond(32'h5555_0055);
        exp_q.push_back(32'h5555_0055);
        #1 expect_ack("mis_next");
        tick();
        idle();

        // Kill with one outstanding and one held
        drive_req(WORD, 32'h50, 1'b1);
        tick();
        drive_req(WORD, 32'h54, 1'b0);
        tick();
        idle();
        mem_kill_i = 1'b1;
        #1 check("kill_stb", 64'(biu_stb_o), 64'd0);
        tick();
        idle();
        respond(32'h66);
        #1;
        check("kill_held_dropped", 64'(biu_stb_o), 64'd0);
        check("kill_supp", 64'(mem_ack_o), 64'd0);
        tick();
        respond(32'h67);
        #1 check("stray_ack", 64'(mem_ack_o), 64'd0);
        tick();
        idle();

        // Bus error on a fresh load, then recovery
        drive_req(WORD, 32'h58, 1'b1);
        tick();
        idle();
        biu_err_i = 1'b1;
        #1;
        check("err_out", 64'(mem_err_o), 64'd1);
        check("err_no_ack", 64'(mem_ack_o), 64'd0);
`ifdef RV_DMEM_ERR_ADR_EN
        tick();
        idle();
        #1 check("err_adr", 64'(mem_err_adr_o), 64'h58);
`else
        tick();
        idle();
`endif
        drive_req(WORD, 32'h5C, 1'b1);
        tick();
        idle();
        respond(32'h7777_0077);
        exp_q.push_back(32'h7777_0077);
        #1 expect_ack("err_next");
        tick();
        idle();

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
